// File: rtl/iterative_alu.sv
// iterative_alu: single-cycle add/sub/and/or plus bit-serial sll/srl with start/done/busy handshake.
// Define ALU_OVERFLOW_DETECT_EN to add the registered signed-overflow flag ovf.
module iterative_alu #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [3:0]         ctrl,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [WIDTH-1:0]   result,
   output logic               zero,
   output logic               done,
   output logic               busy,
`ifdef ALU_OVERFLOW_DETECT_EN
   output logic               ovf,
`endif
   output logic               illegal
);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t state, state_nxt;
   logic [WIDTH-1:0] acc, acc_nxt, op_res, res_nxt, shifted;
   logic [SHAMT_W-1:0] cnt, cnt_nxt;
   logic dir, dir_nxt, legal, is_shift, start_shift, cmp, busy_nxt, ill_nxt, last;
   always_comb begin
      legal  = 1'b1;
      op_res = '0;
      case (ctrl)
         4'b0010: op_res = a + b;
         4'b0100: op_res = a - b;
         4'b0000: op_res = a & b;
         4'b0001: op_res = a | b;
         4'b1000, 4'b1001: op_res = a;
         default: legal = 1'b0;
      endcase
   end
   assign is_shift    = ctrl[3:1] == 3'b100;
   assign start_shift = state == IDLE && start && is_shift && shamt != '0;
   assign shifted     = dir ? acc >> 1 : acc << 1;
   assign last        = cnt == SHAMT_W'(1);
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = start_shift ? SHIFT : IDLE;
         SHIFT:   state_nxt = last ? IDLE : SHIFT;
         default: state_nxt = IDLE;
      endcase
   end
   always_comb begin
      cmp      = state == IDLE ? start && !start_shift : last;
      res_nxt  = state == SHIFT ? shifted : (legal ? op_res : '0);
      acc_nxt  = start_shift ? a : (state == SHIFT ? shifted : acc);
      cnt_nxt  = start_shift ? shamt : (state == SHIFT ? cnt - 1'b1 : cnt);
      dir_nxt  = start_shift ? ctrl[0] : dir;
      busy_nxt = start_shift || (state == SHIFT && !last);
      ill_nxt  = state == IDLE && start && !legal;
   end
`ifdef ALU_OVERFLOW_DETECT_EN
   logic ovf_nxt;
   // Signed overflow only exists for add/sub issued from IDLE; shifts complete with ovf=0
   always_comb begin
      ovf_nxt = 1'b0;
      if (state == IDLE && ctrl == 4'b0010)
         ovf_nxt = a[WIDTH-1] == b[WIDTH-1] && op_res[WIDTH-1] != a[WIDTH-1];
      else if (state == IDLE && ctrl == 4'b0100)
         ovf_nxt = a[WIDTH-1] != b[WIDTH-1] && op_res[WIDTH-1] != a[WIDTH-1];
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) ovf <= 1'b0;
      else if (cmp) ovf <= ovf_nxt;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         acc     <= '0;
         cnt     <= '0;
         dir     <= 1'b0;
         result  <= '0;
         zero    <= 1'b1;
         done    <= 1'b0;
         busy    <= 1'b0;
         illegal <= 1'b0;
      end else begin
         state   <= state_nxt;
         acc     <= acc_nxt;
         cnt     <= cnt_nxt;
         dir     <= dir_nxt;
         done    <= cmp;
         busy    <= busy_nxt;
         illegal <= ill_nxt;
         if (cmp) begin
            result <= res_nxt;
            zero   <= res_nxt == '0;
         end
      end
   end
endmodule
